// File: rtl/template_sad_matcher.sv
// Streams feature bytes against a template held in an external synchronous ROM and
// reports the sum of absolute differences plus a threshold match for each pass.
module template_sad_matcher #(
    parameter int ADDR_WIDTH  = 11,
    parameter int DATA_WIDTH  = 8,
    parameter int TPL_LEN     = 2048,
    parameter int SCORE_WIDTH = ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SCORE_WIDTH-1:0] threshold,
    input  logic [DATA_WIDTH-1:0]  feat_data,
    input  logic                   feat_valid,
    output logic                   feat_ready,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_rd_data,
    output logic                   busy,
    output logic                   done,
    output logic [SCORE_WIDTH-1:0] score,
    output logic                   match
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TPL_LEN - 1);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic [SCORE_WIDTH-1:0] acc_q, acc_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic                   match_q, match_d;

    logic                   xfer;
    logic [DATA_WIDTH:0]    diff_ext;
    logic [DATA_WIDTH-1:0]  abs_diff;
    logic [SCORE_WIDTH-1:0] sum;

    // The sign bit of the widened difference selects which operand was larger.
    always_comb begin
        diff_ext = {1'b0, feat_data} - {1'b0, rom_rd_data};
        abs_diff = diff_ext[DATA_WIDTH] ? DATA_WIDTH'(-diff_ext) : diff_ext[DATA_WIDTH-1:0];
        sum      = acc_q + SCORE_WIDTH'(abs_diff);
        xfer     = feat_valid && (state_q == RUN);
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        score_d  = score_q;
        match_d  = match_q;
        rom_addr = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRIME;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            PRIME: begin
                state_d = RUN;
            end
            RUN: begin
                // Look one entry ahead on a transfer so the ROM keeps pace with the stream;
                // the increment wraps naturally on the final entry.
                rom_addr = xfer ? idx_q + 1'b1 : idx_q;
                if (xfer) begin
                    acc_d = sum;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        score_d = sum;
                        match_d = (sum <= threshold);
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            score_q <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            score_q <= score_d;
            match_q <= match_d;
        end
    end

    assign feat_ready = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign score      = score_q;
    assign match      = match_q;

endmodule

// File: tb/tb_template_sad_matcher.sv
// Bench for template_sad_matcher: a 4-entry instance and a full 2048-entry instance,
// each with its own ROM, checked every cycle against a transfer-level SAD model.
module tb_template_sad_matcher;

    localparam int AW   = 11;
    localparam int DW   = 8;
    localparam int SW   = 19;
    localparam int LEN0 = 4;
    localparam int LEN1 = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start_s  [2];
    logic [SW-1:0] thr_s    [2];
    logic [DW-1:0] fdata_s  [2];
    logic          fvalid_s [2];
    logic          fready_s [2];
    logic [AW-1:0] addr_s   [2];
    logic [DW-1:0] rdata_s  [2];
    logic          busy_s   [2];
    logic          done_s   [2];
    logic [SW-1:0] score_s  [2];
    logic          match_s  [2];

    logic [DW-1:0] tpl0   [LEN0] = '{8'd10, 8'd20, 8'd30, 8'd40};
    logic [DW-1:0] feats0 [LEN0] = '{8'd12, 8'd18, 8'd30, 8'd45};

    template_sad_matcher #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TPL_LEN(LEN0), .SCORE_WIDTH(SW)) dut_small (
        .clk(clk), .rst(rst), .start(start_s[0]), .threshold(thr_s[0]),
        .feat_data(fdata_s[0]), .feat_valid(fvalid_s[0]), .feat_ready(fready_s[0]),
        .rom_addr(addr_s[0]), .rom_rd_data(rdata_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .score(score_s[0]), .match(match_s[0])
    );

    template_sad_matcher #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TPL_LEN(LEN1), .SCORE_WIDTH(SW)) dut_full (
        .clk(clk), .rst(rst), .start(start_s[1]), .threshold(thr_s[1]),
        .feat_data(fdata_s[1]), .feat_valid(fvalid_s[1]), .feat_ready(fready_s[1]),
        .rom_addr(addr_s[1]), .rom_rd_data(rdata_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .score(score_s[1]), .match(match_s[1])
    );

    // Synchronous template ROMs: data for an address appears one edge later.
    always @(posedge clk) begin
        rdata_s[0] <= (addr_s[0] < AW'(LEN0)) ? tpl0[addr_s[0][1:0]] : '0;
        rdata_s[1] <= '0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int tpl_len(input int u);
        return (u == 0) ? LEN0 : LEN1;
    endfunction

    function automatic int tpl_of(input int u, input int i);
        if (u == 0 && i < LEN0) return int'(tpl0[i]);
        return 0;
    endfunction

    function automatic logic [DW-1:0] feat_of(input int u, input int k);
        return (u == 0) ? feats0[k] : 8'hFF;
    endfunction

    // Model: phase 0 idle, 1 priming, 2 streaming, 3 completion cycle.
    int m_mode  [2];
    int m_idx   [2];
    int m_acc   [2];
    int m_score [2];
    bit m_match [2];
    bit m_valid = 1'b0;
    int done_cnt    [2] = '{0, 0};
    int done_period [2] = '{0, 0};

    task automatic model_step(input int u);
        int ea;
        int d;
        if (m_valid) begin
            ea = (m_mode[u] == 2) ? ((m_idx[u] + (fvalid_s[u] ? 1 : 0)) % (1 << AW)) : 0;
            check($sformatf("u%0d_busy", u),   32'(busy_s[u]),   32'(m_mode[u] != 0));
            check($sformatf("u%0d_ready", u),  32'(fready_s[u]), 32'(m_mode[u] == 2));
            check($sformatf("u%0d_done", u),   32'(done_s[u]),   32'(m_mode[u] == 3));
            check($sformatf("u%0d_score", u),  32'(score_s[u]),  32'(m_score[u]));
            check($sformatf("u%0d_match", u),  32'(match_s[u]),  32'(m_match[u]));
            check($sformatf("u%0d_addr", u),   32'(addr_s[u]),   32'(ea));
            if (done_s[u] === 1'b1) begin
                done_cnt[u]++;
                done_period[u] = cyc + 1;
            end
        end
        if (rst) begin
            m_mode[u]  = 0;
            m_idx[u]   = 0;
            m_acc[u]   = 0;
            m_score[u] = 0;
            m_match[u] = 1'b0;
        end else begin
            case (m_mode[u])
                0: if (start_s[u]) begin
                    m_mode[u] = 1;
                    m_idx[u]  = 0;
                    m_acc[u]  = 0;
                end
                1: m_mode[u] = 2;
                2: if (fvalid_s[u]) begin
                    d = int'(fdata_s[u]) - tpl_of(u, m_idx[u]);
                    m_acc[u] += (d < 0) ? -d : d;
                    if (m_idx[u] == tpl_len(u) - 1) begin
                        m_score[u] = m_acc[u];
                        m_match[u] = (m_acc[u] <= int'(thr_s[u]));
                        m_mode[u]  = 3;
                    end
                    m_idx[u]++;
                end
                default: m_mode[u] = 0;
            endcase
        end
    endtask

    always @(negedge clk) begin
        model_step(0);
        model_step(1);
        if (rst) m_valid = 1'b1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One pass: optional stall before each byte, optional start pokes in RUN and in the DONE cycle.
    // lat is measured from the cycle holding start to the cycle holding done.
    task automatic run_pass(input int u, input int thr, input bit stall, input bit poke, output int lat);
        int d0;
        int sp;
        thr_s[u]   = SW'(thr);
        start_s[u] = 1'b1;
        sp = cyc + 1;
        d0 = done_cnt[u];
        tick;
        start_s[u] = 1'b0;
        tick;
        for (int k = 0; k < tpl_len(u); k++) begin
            if (stall) begin
                fvalid_s[u] = 1'b0;
                fdata_s[u]  = 8'hA5;
                tick;
            end
            fvalid_s[u] = 1'b1;
            fdata_s[u]  = feat_of(u, k);
            if (poke && k == 1) start_s[u] = 1'b1;
            tick;
            start_s[u] = 1'b0;
        end
        fvalid_s[u] = 1'b0;
        fdata_s[u]  = '0;
        if (poke) start_s[u] = 1'b1;
        for (int i = 0; i < 8 && done_cnt[u] == d0; i++) begin
            tick;
            start_s[u] = 1'b0;
        end
        check($sformatf("u%0d_done_seen", u), 32'(done_cnt[u] - d0), 32'd1);
        lat = done_period[u] - sp;
    endtask

    int lat;
    int d0;

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start_s[u]  = 1'b0;
            thr_s[u]    = '0;
            fdata_s[u]  = '0;
            fvalid_s[u] = 1'b0;
        end
        tick;
        tick;
        rst = 1'b0;
        tick;
        check("rst_busy",  32'(busy_s[0]),   32'd0);
        check("rst_score", 32'(score_s[0]),  32'd0);
        check("rst_match", 32'(match_s[0]),  32'd0);
        check("rst_ready", 32'(fready_s[0]), 32'd0);
        check("rst_addr",  32'(addr_s[0]),   32'd0);

        // Diffs 2,2,0,5 give 9.
        run_pass(0, 9, 1'b0, 1'b0, lat);
        check("b2b_score", 32'(score_s[0]), 32'd9);
        check("b2b_match", 32'(match_s[0]), 32'd1);
        check("b2b_lat",   32'(lat),        32'd6);
        tick;

        run_pass(0, 8, 1'b0, 1'b0, lat);
        check("thr8_score", 32'(score_s[0]), 32'd9);
        check("thr8_match", 32'(match_s[0]), 32'd0);

        run_pass(0, 9, 1'b1, 1'b0, lat);
        check("stall_score", 32'(score_s[0]), 32'd9);
        check("stall_match", 32'(match_s[0]), 32'd1);

        d0 = done_cnt[0];
        run_pass(0, 9, 1'b0, 1'b1, lat);
        for (int i = 0; i < 5; i++) tick;
        check("poke_one_done", 32'(done_cnt[0] - d0), 32'd1);
        check("poke_idle",     32'(busy_s[0]),        32'd0);
        check("poke_persist",  32'(score_s[0]),       32'd9);

        // 255 * 2048 = 522240, exactly at the threshold.
        run_pass(1, 522240, 1'b0, 1'b0, lat);
        check("full_score", 32'(score_s[1]), 32'd522240);
        check("full_match", 32'(match_s[1]), 32'd1);
        check("full_lat",   32'(lat),        32'd2050);
        tick;

        d0 = done_cnt[0];
        thr_s[0]   = SW'(9);
        start_s[0] = 1'b1;
        tick;
        start_s[0] = 1'b0;
        tick;
        fvalid_s[0] = 1'b1;
        fdata_s[0]  = 8'd12;
        tick;
        fdata_s[0]  = 8'd18;
        tick;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        fvalid_s[0] = 1'b0;
        check("abort_busy",  32'(busy_s[0]),  32'd0);
        check("abort_score", 32'(score_s[0]), 32'd0);
        check("abort_full",  32'(score_s[1]), 32'd0);
        for (int i = 0; i < 6; i++) tick;
        check("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);

        run_pass(0, 9, 1'b0, 1'b0, lat);
        check("after_rst_score", 32'(score_s[0]), 32'd9);
        check("after_rst_lat",   32'(lat),        32'd6);
        tick;
        tick;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/template_sad_matcher.md
TEMPLATE_SAD_MATCHER -- requirements
Module: template_sad_matcher

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11: ROM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: template and feature byte width.
REQ-003 SHALL have parameter TPL_LEN, default 2048: number of entries compared; legal range 1..2^ADDR_WIDTH.
REQ-004 SHALL have parameter SCORE_WIDTH, default ADDR_WIDTH+DATA_WIDTH (19): score width.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1: sole clock; all logic on the rising edge.
REQ-007 Port rst, input, 1: synchronous active-high reset.
REQ-008 Port start, input, 1: begin one comparison pass; sampled only in IDLE.
REQ-009 Port threshold, input, SCORE_WIDTH: match limit; sampled in the DONE transition cycle.
REQ-010 Port feat_data, input, DATA_WIDTH: incoming feature byte.
REQ-011 Port feat_valid, input, 1: feat_data is valid.
REQ-012 Port feat_ready, output, 1: block accepts feat_data this cycle.
REQ-013 Port rom_addr, output, ADDR_WIDTH: address to the template ROM.
REQ-014 Port rom_rd_data, input, DATA_WIDTH: ROM data, valid one cycle after its address is presented.
REQ-015 Port busy, output, 1: a pass is in progress (PRIME, RUN or DONE).
REQ-016 Port done, output, 1: one-cycle pulse marking pass completion.
REQ-017 Port score, output, SCORE_WIDTH: sum of absolute differences (SAD) of the last completed pass.
REQ-018 Port match, output, 1: high when score <= threshold, for the last completed pass.

Function
REQ-019 FSM states SHALL be IDLE, PRIME, RUN and DONE.
REQ-020 IDLE: on start=1, go to PRIME and clear the accumulator and index to 0; otherwise stay.
REQ-021 PRIME SHALL last exactly 1 cycle and then go to RUN; rom_addr=0 in PRIME, so template[0] is valid on entry to RUN.
REQ-022 feat_ready SHALL be 1 only in RUN.
- Transfer = feat_valid & feat_ready.
REQ-023 In RUN, rom_addr SHALL be combinational: idx+1 on a transfer, idx otherwise (full throughput).
- On the final transfer, idx+1 wraps modulo 2^ADDR_WIDTH.
REQ-024 On each transfer, acc SHALL take acc + |feat_data - rom_rd_data|.
- Difference is unsigned and computed at DATA_WIDTH+1 bits.
- idx increments.
REQ-025 While feat_valid=0 in RUN, idx, acc and rom_addr SHALL hold.
REQ-026 On the transfer with idx = TPL_LEN-1, the FSM SHALL go to DONE.
- score is registered with the final sum in the same edge.
- match is registered as (final sum <= threshold) in the same edge.
REQ-027 DONE SHALL last 1 cycle.
- done=1 in that cycle only.
- Then return to IDLE.
REQ-028 rom_addr SHALL be 0 in IDLE and DONE.
REQ-029 start SHALL be ignored in PRIME, RUN and DONE.
- No queuing of start.
REQ-030 score and match SHALL hold their values until the next DONE or reset.
REQ-031 The accumulator SHALL never overflow: (2^DATA_WIDTH-1)*2^ADDR_WIDTH < 2^SCORE_WIDTH.
REQ-032 Latency: with start seen at edge k and no stalls, done=1 in cycle k+TPL_LEN+2.

Reset
REQ-033 While rst=1 at an edge, the block SHALL reset:
- state to IDLE
- idx, acc, score to 0
- match, done, busy, feat_ready to 0
- rom_addr to 0
REQ-034 rst SHALL override start.
- rst mid-pass aborts the pass.
- No done pulse is produced for the aborted pass.
- The first start after rst is accepted normally.

Verification
REQ-035 Reset: rst=1 for 2 cycles in mid-RUN -> next cycle state IDLE; all outputs 0; done never pulses.
REQ-036 TPL_LEN=4, ROM {10,20,30,40}, features {12,18,30,45} back-to-back, threshold=9 -> score=9, match=1.
- Same inputs with threshold=8 -> match=0.
- done is high for exactly 1 cycle, 6 cycles after start.
REQ-037 Same data as REQ-036, feat_valid low on alternate cycles -> score=9.
- rom_addr is stable during each stall.
- feat_ready stays 1 in RUN.
REQ-038 TPL_LEN=2048, ROM all 0x00, features all 0xFF -> score=522240; no wrap; done after 2050 cycles.
REQ-039 start pulsed during RUN and in the DONE cycle -> ignored.
- Exactly one done per accepted start.
- score persists in IDLE until the next pass.
